// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the rate-1/2, K=3 convolutional
// encoder/decoder pair.
//   K            constraint length (encoder memory is K-1 bits)
//   G0/G1_DEFAULT default generator polynomials; MSB taps the current input bit
//   state_t      transmit FSM states
//   nsym()       symbols per frame for a given message length (data + tail)
package conv_pkg;

  localparam int K = 3;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Each message bit yields one symbol, and K-1 zero tail bits flush the
  // encoder memory back to zero at frame end.
  function automatic int nsym(input int msg_len);
    return msg_len + K - 1;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: convolutional encoder kernel. It holds the K-1 bit state
// register and forms the 2-bit code symbol combinationally from the current
// input bit and that state.
//   clk, rst_n  clock, async active-low reset
//   clear       force the encoder state to zero (start of a frame)
//   step        advance the state by one input bit
//   u           current input bit
//   sym         code symbol {g0, g1} for (u, state)
module conv_enc_core
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       step,
  input  logic       u,
  output logic [1:0] sym
);

  // s[K-2] is the most recent past bit, s[0] the oldest.
  logic [K-2:0] s;
  logic [K-1:0] sr;

  assign sr  = {u, s};
  assign sym = {^(sr & G0), ^(sr & G1)};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples pre-edge values, independent of block ordering.
    if (!rst_n) begin
      s <= '0;
    end else if (clear) begin
      s <= '0;
    end else if (step) begin
      s <= sr[K-1:1];
    end
  end

endmodule

// File: rtl/conv_enc_tx.sv
// conv_enc_tx: rate-1/2 convolutional encoder and symbol transmitter.
// Accepts a parallel message, appends K-1 zero tail bits and hands out one
// registered 2-bit symbol per rising edge of the receiver's data_ack.
//   clk, rst_n  clock, async active-low reset
//   msg_in      message word, MSB encoded first
//   msg_valid   message offered (taken only in IDLE)
//   msg_ready   block idle and able to accept a message
//   tx          current code symbol {g0, g1}; holds between requests
//   seq_rdy     frame in progress, receiver may request symbols
//   data_ack    receiver request; each rising edge pulls one symbol
//   frame_done  one-cycle pulse with the last symbol of a frame
module conv_enc_tx
  import conv_pkg::*;
#(
  parameter int           MSG_LEN = 10,
  parameter logic [K-1:0] G0      = G0_DEFAULT,
  parameter logic [K-1:0] G1      = G1_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MSG_LEN-1:0] msg_in,
  input  logic               msg_valid,
  output logic               msg_ready,
  output logic [1:0]         tx,
  output logic               seq_rdy,
  input  logic               data_ack,
  output logic               frame_done
);

  localparam int NSYM  = nsym(MSG_LEN);
  localparam int CNT_W = $clog2(NSYM + 1);

  state_t             state;
  logic [MSG_LEN-1:0] msg_sr;
  logic [CNT_W-1:0]   sym_cnt;
  logic               ack_q;
  logic               ack_edge;
  logic               load;
  logic               step;
  logic               u;
  logic [1:0]         sym;

  assign ack_edge = data_ack & ~ack_q;
  assign load     = (state == IDLE) & msg_valid;
  assign step     = (state == SEND) & ack_edge;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    u = 1'b0;
    if (sym_cnt < CNT_W'(MSG_LEN)) begin
      u = msg_sr[MSG_LEN-1];
    end
  end

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load),
    .step  (step),
    .u     (u),
    .sym   (sym)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      msg_sr     <= '0;
      sym_cnt    <= '0;
      ack_q      <= 1'b0;
      tx         <= 2'b00;
      seq_rdy    <= 1'b0;
      msg_ready  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      // The edge detector runs in every state so a request already high on
      // entry to SEND is not mistaken for a fresh one.
      ack_q      <= data_ack;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (msg_valid) begin
            msg_sr    <= msg_in;
            sym_cnt   <= '0;
            seq_rdy   <= 1'b1;
            msg_ready <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (ack_edge) begin
            tx      <= sym;
            msg_sr  <= msg_sr << 1;
            sym_cnt <= sym_cnt + 1'b1;
            if (sym_cnt == CNT_W'(NSYM - 1)) begin
              frame_done <= 1'b1;
              seq_rdy    <= 1'b0;
              msg_ready  <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_enc_tx.md
# conv_enc_tx

Rate-1/2, constraint-length-3 convolutional encoder and symbol transmitter. Accepts a parallel message word, appends K−1 zero tail bits, and delivers the coded stream as 2-bit symbols over the seq_rdy/data_ack handshake. It is the transmit end of the link that feeds the Viterbi decoder top. The default frame is 10 data bits + 2 tail bits = 12 symbols = 24 coded bits, which matches the decoder's frame.

## Interface
- MSG_LEN, 10: data bits per frame. Symbols per frame NSYM = MSG_LEN+2.
- G0, 3'b111: generator for the upper symbol bit. MSB taps the current input bit.
- G1, 3'b101: generator for the lower symbol bit.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- msg_in  input  MSG_LEN  message; MSB is encoded first.
- msg_valid  input  1  message offered.
- msg_ready  output  1  block can accept a message (IDLE).
- tx  output  2  current code symbol {g0,g1}; registered.
- seq_rdy  output  1  frame in progress; receiver may request symbols.
- data_ack  input  1  receiver request; each rising edge pulls one symbol.
- frame_done  output  1  one-cycle pulse when the last symbol is driven.

## Operation
- States: IDLE, SEND.
- IDLE:
  - msg_ready=1.
  - When msg_valid=1, load msg_in into the shift register, clear encoder state s={s1,s2}=00 and sym_cnt=0, then go to SEND.
- SEND:
  - seq_rdy=1 and msg_ready=0. msg_valid is ignored.
  - An ack edge is data_ack=1 with ack_q=0, where ack_q is data_ack registered every cycle in all states.
  - On each ack edge:
    - u = msg_sr MSB, or 0 once sym_cnt ≥ MSG_LEN (tail).
    - sr={u,s1,s2}; tx <= {^(sr&G0), ^(sr&G1)}.
    - s <= {u,s1}; shift msg_sr left; sym_cnt++.
  - On the ack edge with sym_cnt==NSYM−1: drive the last symbol, pulse frame_done, go to IDLE, seq_rdy <= 0.
- Ack edges in IDLE are ignored. A held-high data_ack yields exactly one symbol.
- tx holds its last value between ack edges and after the frame ends, until the next frame's first ack edge.
- sym_cnt width is $clog2(NSYM+1). No wrap occurs inside a frame.
- Reset, including mid-frame, returns immediately to IDLE:
  - tx=2'b00, seq_rdy=0, frame_done=0.
  - msg_ready=1 after reset release.
  - Encoder state, sym_cnt and ack_q cleared.
  - A partial frame is discarded; there is no resume.

## Timing
- Load: msg_valid sampled at edge N in IDLE → seq_rdy=1 and msg_ready=0 after edge N.
- Symbol latency: ack edge detected at edge N → new tx valid after edge N (same-edge registered update). The receiver may sample it from edge N+1.
- Ack rate: at most one symbol per two cycles, because data_ack must return low for at least one sampled cycle between requests.
- Frame end: at the edge issuing symbol NSYM−1:
  - frame_done=1 for one cycle.
  - seq_rdy=0 and msg_ready=1 after that edge.
- Back-to-back frames: a new msg_valid can load on the cycle after frame end. Minimum frame time is 1 + 2·NSYM cycles.
- Simultaneous events:
  - msg_valid together with the final ack edge: the message is not accepted (msg_ready=0 that cycle).
  - data_ack rising on the load cycle: ignored, since the block is not yet in SEND.

## Structure
- Package conv_pkg holds:
  - K=3 and the default generators 3'b111/3'b101.
  - The state enum {IDLE, SEND}.
  - A function nsym(msg_len)=msg_len+K−1, shared with the decoder top.
- Sub-module conv_enc_core:
  - Owns the K−1 state register and outputs a 2-bit symbol from (u, s, G0, G1).
  - Has a clear input and a step enable.
  - Reusable by a future encoder-based reference model in the decoder bench.
- The top holds the FSM, message shift register, sym_cnt, ack edge detect and output registers.

## Test plan
- Reset mid-frame: after 5 symbols, pulse rst_n low → tx=00, seq_rdy=0, msg_ready=1. A new frame then starts with encoder state 00; its first symbol for MSB=1 is 11.
- Nominal frame: msg_in=10'b1011000000, 12 ack pulses → tx sequence 11 10 00 01 01 11 00 00 00 00 00 00, i.e. 24'b111000010111000000000000. frame_done occurs on the 12th.
- All ones: msg_in=10'b1111111111 → 11 01 10 10 10 10 10 10 10 10 01 11. Tail flushes the state to 00.
- Held ack: data_ack held high for 6 cycles → exactly one symbol advance. Ack pulses in IDLE → tx unchanged, sym_cnt unchanged.
- Back-to-back: second msg_valid held during the final ack edge → accepted one cycle later. Its first symbol starts from state 00 regardless of the prior frame.
- Loop-back: connect to the decoder top with the nominal frame → decoder output equals 10'b1011000000.
